// File: rtl/wdt_kick_sched.sv
// Watchdog kick sequencer: configures a WDT slave over a write-only MM port and
// periodically kicks it while software heartbeats keep arriving.
module wdt_kick_sched #(
  parameter int MM_ADDR_WIDTH = 8,
  parameter int MM_DATA_WIDTH = 16,
  parameter logic [MM_ADDR_WIDTH-1:0] WDT_CTRL_ADDR = 'h0A,
  parameter logic [MM_ADDR_WIDTH-1:0] WDT_VAL_ADDR  = 'h0C
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_n_i,
  input  logic                     clk_8hz_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     heartbeat_i,
  input  logic [12:0]              cfg_timeout_i,
  input  logic [15:0]              cfg_period_i,
  input  logic [MM_ADDR_WIDTH-1:0] host_addr_i,
  input  logic [MM_DATA_WIDTH-1:0] host_wdata_i,
  input  logic                     host_we_i,
  output logic                     host_gnt_o,
  output logic [MM_ADDR_WIDTH-1:0] mm_m_addr_o,
  output logic [MM_DATA_WIDTH-1:0] mm_m_wdata_o,
  output logic                     mm_m_we_o,
  output logic                     running_o,
  output logic                     starve_o,
  output logic [2:0]               state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CFG_VAL = 3'd1,
    S_CFG_EN  = 3'd2,
    S_RUN     = 3'd3,
    S_KICK    = 3'd4,
    S_DIS     = 3'd5
  } state_t;

  state_t      r_state;
  logic        r_sync1, r_sync2, r_sync3;
  logic [15:0] r_cnt;
  logic        r_hb;
  logic        r_starve;
  logic        r_stop_pend;

  logic                     w_tick;
  logic                     w_seq_req;
  logic                     w_gnt;
  logic                     w_seq_go;
  logic [15:0]              w_period;
  logic [15:0]              w_cnt_inc;
  logic                     w_period_hit;
  logic [MM_ADDR_WIDTH-1:0] w_seq_addr;
  logic [MM_DATA_WIDTH-1:0] w_seq_data;

  assign w_tick       = r_sync2 & ~r_sync3;
  assign w_seq_req    = (r_state == S_CFG_VAL) || (r_state == S_CFG_EN) ||
                        (r_state == S_KICK)    || (r_state == S_DIS);
  // Host request/grant: host_we_i is a one-cycle request that is either granted
  // that same cycle (host_gnt_o=1, port carries the host write) or dropped; the
  // host retries. CFG_EN is never interrupted so VAL/EN stay back-to-back.
  assign w_gnt        = host_we_i && (r_state != S_CFG_EN);
  assign w_seq_go     = w_seq_req && !w_gnt;
  assign w_period     = (cfg_period_i == 16'd0) ? 16'd1 : cfg_period_i;
  assign w_cnt_inc    = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign w_period_hit = w_tick && (w_cnt_inc >= w_period);

  always_comb begin
    w_seq_addr = '0;
    w_seq_data = '0;
    case (r_state)
      S_CFG_VAL: begin
        w_seq_addr = WDT_VAL_ADDR;
        w_seq_data = MM_DATA_WIDTH'({3'b000, cfg_timeout_i});
      end
      S_CFG_EN: begin
        w_seq_addr = WDT_CTRL_ADDR;
        w_seq_data = MM_DATA_WIDTH'(16'h0001);
      end
      S_KICK: begin
        w_seq_addr = WDT_CTRL_ADDR;
        w_seq_data = MM_DATA_WIDTH'(16'h5A01);
      end
      S_DIS: begin
        w_seq_addr = WDT_CTRL_ADDR;
        w_seq_data = '0;
      end
      default: begin
        w_seq_addr = '0;
        w_seq_data = '0;
      end
    endcase
  end

  always_comb begin
    mm_m_addr_o  = '0;
    mm_m_wdata_o = '0;
    mm_m_we_o    = 1'b0;
    if (w_gnt) begin
      mm_m_addr_o  = host_addr_i;
      mm_m_wdata_o = host_wdata_i;
      mm_m_we_o    = 1'b1;
    end else if (w_seq_req) begin
      mm_m_addr_o  = w_seq_addr;
      mm_m_wdata_o = w_seq_data;
      mm_m_we_o    = 1'b1;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync3     <= 1'b0;
      r_cnt       <= '0;
      r_hb        <= 1'b0;
      r_starve    <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      r_sync1 <= clk_8hz_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      case (r_state)
        S_IDLE: begin
          r_stop_pend <= 1'b0;
          if (start_i && !stop_i) r_state <= S_CFG_VAL;
        end
        S_CFG_VAL: begin
          if (stop_i) r_stop_pend <= 1'b1;
          if (w_seq_go) r_state <= S_CFG_EN;
        end
        S_CFG_EN: begin
          r_cnt       <= '0;
          r_hb        <= 1'b0;
          r_stop_pend <= 1'b0;
          r_state     <= (stop_i || r_stop_pend) ? S_DIS : S_RUN;
        end
        S_RUN: begin
          if (stop_i) begin
            r_state <= S_DIS;
          end else if (w_period_hit) begin
            r_cnt <= '0;
            if (r_hb) r_state  <= S_KICK;
            else      r_starve <= 1'b1;
          end else if (w_tick) begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_KICK: begin
          if (w_tick) r_cnt <= w_cnt_inc;
          if (stop_i) r_stop_pend <= 1'b1;
          if (w_seq_go) begin
            r_hb        <= 1'b0;
            r_starve    <= 1'b0;
            r_stop_pend <= 1'b0;
            r_state     <= (stop_i || r_stop_pend) ? S_DIS : S_RUN;
          end
        end
        S_DIS: begin
          r_stop_pend <= 1'b0;
          if (w_seq_go) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // A heartbeat always lands, even on the cycle that consumes the flag.
      if (heartbeat_i) r_hb <= 1'b1;
      if (start_i) r_starve <= 1'b0;
    end
  end

  assign host_gnt_o = w_gnt;
  assign running_o  = (r_state == S_RUN) || (r_state == S_KICK);
  assign starve_o   = r_starve;
  assign state_o    = r_state;

endmodule

// File: tb/tb_wdt_kick_sched.sv
// Directed bench for wdt_kick_sched: cycle-by-cycle vector tables plus
// hand-built tick sequences for the RUN/KICK and reset corner cases.
module tb_wdt_kick_sched;

  logic        clk_sys_i = 1'b0;
  logic        rst_n_i   = 1'b0;
  logic        clk_8hz_i = 1'b0;
  logic        start_i = 1'b0, stop_i = 1'b0, heartbeat_i = 1'b0;
  logic [12:0] cfg_timeout_i = 13'd16;
  logic [15:0] cfg_period_i  = 16'd4;
  logic [7:0]  host_addr_i  = '0;
  logic [15:0] host_wdata_i = '0;
  logic        host_we_i    = 1'b0;
  logic        host_gnt_o, mm_m_we_o, running_o, starve_o;
  logic [7:0]  mm_m_addr_o;
  logic [15:0] mm_m_wdata_o;
  logic [2:0]  state_o;

  int n_chk = 0;
  int n_err = 0;

  wdt_kick_sched dut (
    .clk_sys_i(clk_sys_i), .rst_n_i(rst_n_i), .clk_8hz_i(clk_8hz_i),
    .start_i(start_i), .stop_i(stop_i), .heartbeat_i(heartbeat_i),
    .cfg_timeout_i(cfg_timeout_i), .cfg_period_i(cfg_period_i),
    .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i), .host_we_i(host_we_i),
    .host_gnt_o(host_gnt_o), .mm_m_addr_o(mm_m_addr_o), .mm_m_wdata_o(mm_m_wdata_o),
    .mm_m_we_o(mm_m_we_o), .running_o(running_o), .starve_o(starve_o), .state_o(state_o)
  );

  // clock/reset: posedges at 5,15,...; inputs change on negedges
  always #5 clk_sys_i = ~clk_sys_i;

  typedef struct {
    logic        clk8, start, stop, hb, hwe;
    logic [7:0]  haddr;
    logic [15:0] hdata;
    logic [2:0]  e_state;
    logic        e_we;
    logic [7:0]  e_addr;
    logic [15:0] e_data;
    logic        e_gnt, e_starve;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic clk8, logic st, logic sp, logic hb, logic hwe,
                              logic [7:0] ha, logic [15:0] hd, logic [2:0] es,
                              logic ewe, logic [7:0] ea, logic [15:0] ed,
                              logic eg, logic esv);
    vec_t v;
    v.clk8 = clk8; v.start = st; v.stop = sp; v.hb = hb; v.hwe = hwe;
    v.haddr = ha; v.hdata = hd; v.e_state = es; v.e_we = ewe;
    v.e_addr = ea; v.e_data = ed; v.e_gnt = eg; v.e_starve = esv;
    return v;
  endfunction

  // scoreboard comparison of every output against the expected record
  task automatic chk(input string tag, input logic [2:0] es, input logic ewe,
                     input logic [7:0] ea, input logic [15:0] ed,
                     input logic eg, input logic esv);
    logic [30:0] act, exp;
    logic        erun;
    erun = (es == 3'd3) || (es == 3'd4);
    act  = {state_o, mm_m_we_o, mm_m_addr_o, mm_m_wdata_o, host_gnt_o, starve_o, running_o};
    exp  = {es, ewe, ea, ed, eg, esv, erun};
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got state=%0d we=%b addr=%h data=%h gnt=%b starve=%b run=%b, want state=%0d we=%b addr=%h data=%h gnt=%b starve=%b run=%b",
               tag, state_o, mm_m_we_o, mm_m_addr_o, mm_m_wdata_o, host_gnt_o, starve_o, running_o,
               es, ewe, ea, ed, eg, esv, erun);
    end
  endtask

  // driver: one clock cycle per vector, checked just before the next posedge
  task automatic apply_vec(input string tag, input vec_t v);
    @(negedge clk_sys_i);
    clk_8hz_i = v.clk8; start_i = v.start; stop_i = v.stop; heartbeat_i = v.hb;
    host_we_i = v.hwe; host_addr_i = v.haddr; host_wdata_i = v.hdata;
    #3;
    chk(tag, v.e_state, v.e_we, v.e_addr, v.e_data, v.e_gnt, v.e_starve);
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) apply_vec($sformatf("%s[%0d]", name, i), tbl[i]);
    tbl.delete();
  endtask

  // First three cycles of one 8 Hz period; the synchronized tick lands on the third.
  task automatic run_pre(input string tag, input logic hb, input logic st);
    apply_vec({tag, ".p0"}, mk(1, 0, 0, hb, 0, 0, 0, 3, 0, 0, 0, 0, st));
    apply_vec({tag, ".p1"}, mk(1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, st));
    apply_vec({tag, ".p2"}, mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, st));
  endtask

  task automatic run_unit(input string tag, input logic hb, input logic kick,
                          input logic st_pre, input logic st_post);
    run_pre(tag, hb, st_pre);
    if (kick) apply_vec({tag, ".p3"}, mk(0, 0, 0, 0, 0, 0, 0, 4, 1, 8'h0A, 16'h5A01, 0, st_post));
    else      apply_vec({tag, ".p3"}, mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, st_post));
  endtask

  initial begin
    // reset state
    #3 chk("reset_early", 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk_sys_i);
    #3 chk("reset_held", 0, 0, 0, 0, 0, 0);
    @(negedge clk_sys_i);
    rst_n_i = 1'b1;

    // bring-up: VAL then CTRL enable on consecutive cycles
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 8'h0C, 16'h0010, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 8'h0A, 16'h0001, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0));
    run_table("bringup");

    // heartbeat every 2 ticks: kick after every 4th tick
    for (int u = 1; u <= 8; u++)
      run_unit($sformatf("hb_u%0d", u), (u % 2) == 1, (u % 4) == 0, 0, 0);
    // no heartbeat: starve after 4th tick, no write
    for (int u = 9; u <= 12; u++)
      run_unit($sformatf("starve_u%0d", u), 0, 0, 0, u == 12);
    // heartbeat then 4 ticks: kick, starve clears once the kick is written
    for (int u = 13; u <= 16; u++)
      run_unit($sformatf("recover_u%0d", u), u == 13, u == 16, 1, 1);
    for (int u = 17; u <= 19; u++)
      run_unit($sformatf("pre_stall_u%0d", u), u == 17, 0, 0, 0);

    // host write held off the kick by one cycle; heartbeat on the kick write survives
    run_pre("stall_u20", 0, 0);
    apply_vec("stall_host", mk(0, 0, 0, 0, 1, 8'h22, 16'hBEEF, 4, 1, 8'h22, 16'hBEEF, 1, 0));
    apply_vec("stall_kick", mk(0, 0, 0, 1, 0, 0, 0, 4, 1, 8'h0A, 16'h5A01, 0, 0));
    apply_vec("stall_back", mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0));
    for (int u = 21; u <= 24; u++)
      run_unit($sformatf("latched_u%0d", u), 0, u == 24, 0, 0);

    // stop during KICK: kick completes, then disable, then IDLE
    for (int u = 25; u <= 27; u++)
      run_unit($sformatf("stopk_u%0d", u), u == 25, 0, 0, 0);
    run_pre("stopk_u28", 0, 0);
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 4, 1, 8'h0A, 16'h5A01, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 1, 8'h0A, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_table("stop_kick");

    // start+stop together does nothing; host stalls CFG_VAL, stop pending,
    // host locked out of CFG_EN, then disable
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h33, 16'h1234, 1, 1, 8'h33, 16'h1234, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 8'h33, 16'h1234, 1, 1, 8'h33, 16'h1234, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 8'h0C, 16'h0010, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h44, 16'h5678, 2, 1, 8'h0A, 16'h0001, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 1, 8'h0A, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_table("arb_stop");

    // period 0 behaves as 1; full-width timeout
    cfg_period_i  = 16'd0;
    cfg_timeout_i = 13'h1FFF;
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 8'h0C, 16'h1FFF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 8'h0A, 16'h0001, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0));
    run_table("period0");
    run_unit("p0_kick", 1, 1, 0, 0);
    run_unit("p0_starve", 0, 0, 0, 1);

    // stop in RUN; starve is sticky through IDLE until start
    cfg_period_i = 16'd4;
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 1, 8'h0A, 16'h0000, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 8'h0C, 16'h1FFF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 8'h0A, 16'h0001, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0));
    run_table("restart");

    // reset asserted as the KICK state begins: no write, everything cleared
    for (int u = 1; u <= 4; u++)
      run_unit($sformatf("rst_u%0d", u), 0, 0, 0, u == 4);
    for (int u = 5; u <= 7; u++)
      run_unit($sformatf("rst_u%0d", u), u == 5, 0, 1, 1);
    run_pre("rst_u8", 0, 1);
    @(posedge clk_sys_i);
    #1 rst_n_i = 1'b0;
    #2 chk("rst_in_kick", 0, 0, 0, 0, 0, 0);
    @(negedge clk_sys_i);
    rst_n_i = 1'b1;
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_table("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
